mem_arbiter: RTL

Two-port round-robin arbiter that shares the single main-memory port between two cache controllers (instruction-side port 0, data-side port 1). Each requester sees a private copy of the memory interface (mem_read/mem_write/m_addr/m_w_data in, m_r_data/main_mem_ack out). The arbiter grants one requester at a time, holds the grant until main_mem_ack, and inserts a one-cycle release gap between transactions. A watchdog aborts grants that never receive an acknowledge.

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between two cache controllers.
// Grant appears 1 cycle after a request, acks pass through in the same cycle, and a one-cycle release gap follows each grant.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_mem_read,
    input  logic              r0_mem_write,
    input  logic [ADDR_W-1:0] r0_m_addr,
    input  logic [LINE_W-1:0] r0_m_w_data,
    output logic [LINE_W-1:0] r0_m_r_data,
    output logic              r0_main_mem_ack,
    input  logic              r1_mem_read,
    input  logic              r1_mem_write,
    input  logic [ADDR_W-1:0] r1_m_addr,
    input  logic [LINE_W-1:0] r1_m_w_data,
    output logic [LINE_W-1:0] r1_m_r_data,
    output logic              r1_main_mem_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_w_data,
    input  logic [LINE_W-1:0] m_r_data,
    input  logic              main_mem_ack,
    output logic [1:0]        grant,
    output logic              arb_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT0  = 2'd1;
    localparam logic [1:0] S_GRANT1  = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam bit WD_EN = (TIMEOUT > 0);
    localparam int CNT_W = WD_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WD_EN ? TIMEOUT - 1 : 0);

    logic [1:0]       state, state_nxt, pick;
    logic             last_grant, last_grant_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             arb_err_nxt;
    logic             req0, req1, wd_expire;

    assign req0      = r0_mem_read | r0_mem_write;
    assign req1      = r1_mem_read | r1_mem_write;
    assign wd_expire = WD_EN && (cnt == CNT_LAST);

    // On a tie the port that did not hold the last grant wins.
    always_comb begin
        pick = S_IDLE;
        if (req0 && req1)
            pick = last_grant ? S_GRANT0 : S_GRANT1;
        else if (req0)
            pick = S_GRANT0;
        else if (req1)
            pick = S_GRANT1;
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        cnt_nxt        = '0;
        arb_err_nxt    = arb_err;
        case (state)
            S_GRANT0: begin
                if (main_mem_ack || !req0 || wd_expire) begin
                    state_nxt      = S_RELEASE;
                    last_grant_nxt = 1'b0;
                    if (wd_expire && !main_mem_ack)
                        arb_err_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_GRANT1: begin
                if (main_mem_ack || !req1 || wd_expire) begin
                    state_nxt      = S_RELEASE;
                    last_grant_nxt = 1'b1;
                    if (wd_expire && !main_mem_ack)
                        arb_err_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = pick;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            arb_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
            arb_err    <= arb_err_nxt;
        end
    end

    // Write has priority over read when a port raises both.
    always_comb begin
        grant           = 2'b00;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        m_addr          = '0;
        m_w_data        = '0;
        r0_main_mem_ack = 1'b0;
        r0_m_r_data     = '0;
        r1_main_mem_ack = 1'b0;
        r1_m_r_data     = '0;
        case (state)
            S_GRANT0: begin
                grant           = 2'b01;
                mem_write       = r0_mem_write;
                mem_read        = r0_mem_read & ~r0_mem_write;
                m_addr          = r0_m_addr;
                m_w_data        = r0_m_w_data;
                r0_main_mem_ack = main_mem_ack;
                r0_m_r_data     = m_r_data;
            end
            S_GRANT1: begin
                grant           = 2'b10;
                mem_write       = r1_mem_write;
                mem_read        = r1_mem_read & ~r1_mem_write;
                m_addr          = r1_m_addr;
                m_w_data        = r1_m_w_data;
                r1_main_mem_ack = main_mem_ack;
                r1_m_r_data     = m_r_data;
            end
            default: ;
        endcase
    end

endmodule
